alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It accepts one operation per transaction on a valid/ready input port and returns a registered result plus status flags on a valid/ready output port. Logic and shift ops finish in one cycle; multiply and divide are iterative and take WIDTH cycles. It sits between the instruction decode stage and the writeback register.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operation request valid.
- `in_ready`  out  1  block can accept a request.
- `op`  in  4  opcode, map below.
- `operand_a`  in  WIDTH  first operand, unsigned.
- `operand_b`  in  WIDTH  second operand, unsigned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  primary result.
- `result_hi`  out  WIDTH  MUL: high half of the product; DIV: remainder; otherwise 0.
- `flags`  out  5  {dz, ovf, neg, zero, carry}.

## Operation
- Opcode map:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL1, 5 SHR1, 6 ROL1, 7 ROR1.
  - 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR.
  - E GT (result = 1 when a>b, unsigned), F EQ (result = 1 when a==b).
- Operands and op are captured into registers on accept. Inputs may change afterwards without effect.
- FSM states and transitions:
  - IDLE → EXEC on accept when op is MUL or DIV and b≠0.
  - IDLE → DONE on accept for every other op.
  - EXEC → DONE when the iteration counter reaches WIDTH−1.
  - DONE → IDLE when out_valid && out_ready.
- `in_ready` = (state==IDLE). Requests never overlap.
- MUL: shift-add over WIDTH iterations; {result_hi, result} = a*b, a 2·WIDTH-bit product.
- DIV: restoring division over WIDTH iterations; result = a/b, result_hi = a%b.
- DIV with b=0: goes straight to DONE with result=0, result_hi=a, dz=1.
- Flags:
  - carry: ADD carry-out; SUB borrow (a<b); SHL1 bit shifted out (a[W−1]); SHR1 bit shifted out (a[0]); 0 for all other ops.
  - zero: result==0.
  - neg: result[WIDTH−1].
  - ovf: ADD/SUB two's-complement signed overflow; MUL result_hi≠0; 0 for all other ops.
  - dz: set only by DIV with b=0.
- Outputs stay stable while out_valid=1 && out_ready=0.

## Timing
- Reset: state=IDLE; in_ready=1; out_valid=0; result, result_hi, flags all 0.
- Accept at edge N:
  - Single-cycle ops: out_valid=1 from edge N+1.
  - MUL/DIV (b≠0): out_valid=1 from edge N+WIDTH+1.
- Result handshake at edge M (out_valid && out_ready): out_valid=0 and in_ready=1 from edge M+1.
- Maximum throughput is 1 single-cycle op per 2 clocks.
- An rst_n assertion mid-EXEC or mid-DONE aborts the operation immediately, with no partial result emitted. All outputs return to their reset values asynchronously.
- No combinational path exists from any input to any output except through state. `in_ready` depends on state only.

## Configuration
- `ALU_MULDIV_EN` defined: MUL and DIV are built as described.
- Undefined:
  - No iterative datapath and no EXEC state.
  - Op 2 and op 3 complete in one cycle with result=0, result_hi=0, and flags = {dz=0, ovf=0, neg=0, zero=1, carry=0}.

## Test plan
- WIDTH=8, ADD a=0xF0 b=0x20 → after 1 cycle, result=0x10, carry=1, zero=0, ovf=0.
- WIDTH=8, SUB a=0x80 b=0x01 → result=0x7F, carry=0, ovf=1, neg=0.
- WIDTH=8, MUL a=0xFF b=0x02 → out_valid 9 cycles after accept, result=0xFE, result_hi=0x01, ovf=1. in_ready stays 0 throughout.
- WIDTH=8, DIV a=100 b=7 → result=14, result_hi=2 after 9 cycles.
- WIDTH=8, DIV a=5 b=0 → result=0, result_hi=5, dz=1 after 1 cycle.
- WIDTH=16, ROL1 a=0x8001 with out_ready held low for 5 cycles → result=0x0003, held stable until the handshake. Then assert rst_n=0 during a MUL → out_valid=0 and in_ready=1 at once, and no result is emitted after release.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq -- sequential, handshaked ALU.
//
// Accepts one operation per valid/ready transaction. The result and status
// flags are held in registers and presented on a valid/ready output port.
// Logic, add/sub, shift and compare ops complete in one cycle. MUL
// (shift-add) and DIV (restoring) run iteratively for WIDTH cycles.
//
// Build option:
//   ALU_MULDIV_EN  When defined, the iterative MUL/DIV datapath and the EXEC
//                  state are built. When undefined, op 2 and op 3 complete in
//                  one cycle with result = result_hi = 0 and only the zero
//                  flag set.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  block is idle and can accept a request
//   op         in   4-bit opcode (0 ADD .. F EQ)
//   operand_a  in   first operand, unsigned
//   operand_b  in   second operand, unsigned
//   out_valid  out  result valid
//   out_ready  in   consumer accepts the result
//   result     out  primary result
//   result_hi  out  MUL high half / DIV remainder / 0
//   flags      out  {dz, ovf, neg, zero, carry}
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags
);

    localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL  = 4'h2, OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL1 = 4'h4, OP_SHR1 = 4'h5, OP_ROL1 = 4'h6, OP_ROR1 = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8, OP_OR   = 4'h9, OP_XOR  = 4'hA, OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT   = 4'hE, OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
        EXEC = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] result_q, result_hi_q;
    logic [4:0]       flags_q;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs and captured on
    // accept, so later input changes have no effect.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_carry, sc_ovf, sc_dz;
    logic [4:0]       sc_flags;

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        sc_res   = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_dz    = 1'b0;
        sum      = {1'b0, operand_a} + {1'b0, operand_b};
        diff     = {1'b0, operand_a} - {1'b0, operand_b};
        case (op)
            OP_ADD: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                           (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = diff[WIDTH-1:0];
                sc_carry = diff[WIDTH];           // borrow: a < b
                sc_ovf   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                           (diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            // MUL reaching this path has b == 0 (or no MUL/DIV support):
            // every output stays at its zero default.
            OP_MUL: ;
            OP_DIV: begin
`ifdef ALU_MULDIV_EN
                // Divide by zero: quotient 0, remainder = dividend.
                if (operand_b == '0) begin
                    sc_hi = operand_a;
                    sc_dz = 1'b1;
                end
`endif
            end
            OP_SHL1: begin
                sc_res   = {operand_a[WIDTH-2:0], 1'b0};
                sc_carry = operand_a[WIDTH-1];
            end
            OP_SHR1: begin
                sc_res   = {1'b0, operand_a[WIDTH-1:1]};
                sc_carry = operand_a[0];
            end
            OP_ROL1: sc_res = {operand_a[WIDTH-2:0], operand_a[WIDTH-1]};
            OP_ROR1: sc_res = {operand_a[0], operand_a[WIDTH-1:1]};
            OP_AND:  sc_res = operand_a & operand_b;
            OP_OR:   sc_res = operand_a | operand_b;
            OP_XOR:  sc_res = operand_a ^ operand_b;
            OP_NOR:  sc_res = ~(operand_a | operand_b);
            OP_NAND: sc_res = ~(operand_a & operand_b);
            OP_XNOR: sc_res = ~(operand_a ^ operand_b);
            OP_GT:   sc_res = WIDTH'(operand_a > operand_b);
            OP_EQ:   sc_res = WIDTH'(operand_a == operand_b);
            default: ;
        endcase
    end

    assign sc_flags = {sc_dz, sc_ovf, sc_res[WIDTH-1], (sc_res == '0), sc_carry};

    logic accept;
    assign accept = in_valid && (state_q == IDLE);

`ifdef ALU_MULDIV_EN
    // ------------------------------------------------------------------
    // Iterative MUL/DIV datapath. acc_q/lo_q form a 2*WIDTH shift pair:
    //   MUL: {acc, lo} starts at {0, b}; each step adds a into acc when
    //        lo[0] is set, then shifts the pair right. Ends as {hi, lo} = a*b.
    //   DIV: {acc, lo} starts at {0, a}; each step shifts the pair left and
    //        subtracts b from acc when it fits, shifting the quotient bit
    //        into lo. Ends as {remainder, quotient}.
    // ------------------------------------------------------------------
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, lo_q, dv_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic             start;

    logic [WIDTH:0]   mul_sum, div_trial;
    logic             div_fit;
    logic [WIDTH-1:0] it_acc, it_lo;

    assign start = accept && ((op == OP_MUL) || (op == OP_DIV)) && (operand_b != '0);

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
        div_trial = {acc_q, lo_q[WIDTH-1]} - {1'b0, dv_q};
        div_fit   = !div_trial[WIDTH];
        if (is_div_q) begin
            it_acc = div_fit ? div_trial[WIDTH-1:0] : {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
            it_lo  = {lo_q[WIDTH-2:0], div_fit};
        end else begin
            it_acc = mul_sum[WIDTH:1];
            it_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // NOTE: the working registers are reset too, so a reset mid-operation
    // leaves no stale partial product or remainder behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            lo_q     <= '0;
            dv_q     <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            lo_q     <= (op == OP_MUL) ? operand_b : operand_a;
            dv_q     <= (op == OP_MUL) ? operand_a : operand_b;
            cnt_q    <= '0;
            is_div_q <= (op == OP_DIV);
        end else if (state_q == EXEC) begin
            acc_q <= it_acc;
            lo_q  <= it_lo;
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef ALU_MULDIV_EN
                if (start)       state_d = EXEC;
                else if (accept) state_d = DONE;
`else
                if (accept)      state_d = DONE;
`endif
            end
`ifdef ALU_MULDIV_EN
            EXEC: if (cnt_q == LAST) state_d = DONE;
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers: loaded on a single-cycle accept or on the last
    // iteration, then held until the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else if (accept && (state_d == DONE)) begin
            result_q    <= sc_res;
            result_hi_q <= sc_hi;
            flags_q     <= sc_flags;
        end
`ifdef ALU_MULDIV_EN
        else if ((state_q == EXEC) && (cnt_q == LAST)) begin
            result_q    <= it_lo;
            result_hi_q <= it_acc;
            flags_q     <= {1'b0, !is_div_q && (it_acc != '0), it_lo[WIDTH-1],
                            (it_lo == '0), 1'b0};
        end
`endif
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

endmodule
